// File: rtl/cd_stream_pkg.sv
// cd_stream_pkg: header field positions and router FSM state encoding.
//   HDR_AUDIO_BIT  header bit selecting audio (1) or data (0) sector
//   HDR_LEN_MSB    top bit of the payload-length field (bits [HDR_LEN_MSB:0])
//   LEN_W          width of the payload length and word counter
package cd_stream_pkg;
   localparam int HDR_AUDIO_BIT = 15;
   localparam int HDR_LEN_MSB = 10;
   localparam int LEN_W = HDR_LEN_MSB + 1;
   typedef enum logic [2:0] {IDLE, HDR, DATA, AUDIO, DROP} state_e;
endpackage

// File: rtl/cd_fifo_watermark.sv
// cd_fifo_watermark: registered almost-full flag from a FIFO fill level.
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   level        in   FIFO fill level in words
//   almost_full  out  registered (DEPTH - level) < AF_MARGIN
module cd_fifo_watermark #(
   parameter int LEVEL_W = 11,
   parameter int DEPTH = 2048,
   parameter int AF_MARGIN = 64
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [LEVEL_W-1:0] level,
   output logic               almost_full
);
   logic af_q, af_d;
   // Signed 32-bit arithmetic so a level above DEPTH cannot wrap the free space.
   always_comb af_d = (DEPTH - int'(level)) < AF_MARGIN;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) af_q <= 1'b0;
      else af_q <= af_d;
   assign almost_full = af_q;
endmodule

// File: rtl/cd_stream_router.sv
// cd_stream_router: routes CD_DATA sectors to the data or CDDA audio FIFO.
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   cd_dat_download             high for the whole transfer
//   cdctl_wr, cd_data_out       word strobe and 16-bit stream word
//   data_level, aud_level       FIFO fill levels (must be able to represent DEPTH)
//   data_wr, aud_wr, fifo_wdata FIFO write strobes and payload, one cycle after strobe
//   CD_almost_full, AUDIO_almost_full  registered backpressure flags
//   sector_done, sector_is_audio       completion pulse and type of last sector
//   err_short, err_overflow, err_clr   sticky errors and their clear pulse
module cd_stream_router
   import cd_stream_pkg::*;
#(
   parameter int LEVEL_W = 11,
   parameter int DATA_DEPTH = 2048,
   parameter int AUD_DEPTH = 2048,
   parameter int AF_MARGIN = 64
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               cd_dat_download,
   input  logic               cdctl_wr,
   input  logic [15:0]        cd_data_out,
   input  logic [LEVEL_W-1:0] data_level,
   input  logic [LEVEL_W-1:0] aud_level,
   output logic               data_wr,
   output logic               aud_wr,
   output logic [15:0]        fifo_wdata,
   output logic               CD_almost_full,
   output logic               AUDIO_almost_full,
   output logic               sector_done,
   output logic               sector_is_audio,
   output logic               err_short,
   output logic               err_overflow,
   input  logic               err_clr
);
   state_e state_q, state_d;
   logic dl_q;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [15:0] wdata_q, wdata_d;
   logic data_wr_q, data_wr_d, aud_wr_q, aud_wr_d;
   logic last_q, last_d, last_aud_q, last_aud_d;
   logic done_q, is_aud_q, is_aud_d;
   logic err_short_q, err_short_d, err_ovf_q, err_ovf_d;
   logic short_set, ovf_set, full;
   logic data_full, aud_full;
   assign data_full = int'(data_level) == DATA_DEPTH;
   assign aud_full = int'(aud_level) == AUD_DEPTH;
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      cnt_d = cnt_q;
      wdata_d = wdata_q;
      data_wr_d = 1'b0;
      aud_wr_d = 1'b0;
      last_d = 1'b0;
      last_aud_d = last_aud_q;
      short_set = 1'b0;
      ovf_set = 1'b0;
      full = 1'b0;
      if (!cd_dat_download) begin
         // Leaving mid-payload means the sector was cut short.
         state_d = IDLE;
         short_set = state_q == DATA || state_q == AUDIO;
      end else begin
         case (state_q)
            IDLE: if (!dl_q) state_d = HDR;
            HDR: if (cdctl_wr) begin
               len_d = cd_data_out[HDR_LEN_MSB:0];
               cnt_d = '0;
               state_d = len_d == '0 ? DROP : cd_data_out[HDR_AUDIO_BIT] ? AUDIO : DATA;
            end
            DATA, AUDIO: if (cdctl_wr) begin
               // A word hitting a full FIFO is dropped but still counted so framing holds.
               full = state_q == AUDIO ? aud_full : data_full;
               wdata_d = cd_data_out;
               data_wr_d = state_q == DATA && !full;
               aud_wr_d = state_q == AUDIO && !full;
               ovf_set = full;
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == len_q) begin
                  last_d = 1'b1;
                  last_aud_d = state_q == AUDIO;
                  state_d = HDR;
               end
            end
            default: ;
         endcase
      end
      is_aud_d = last_q ? last_aud_q : is_aud_q;
      err_short_d = short_set | (err_short_q & ~err_clr);
      err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
   end
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         dl_q <= 1'b0;
         len_q <= '0;
         cnt_q <= '0;
         wdata_q <= '0;
         data_wr_q <= 1'b0;
         aud_wr_q <= 1'b0;
         last_q <= 1'b0;
         last_aud_q <= 1'b0;
         done_q <= 1'b0;
         is_aud_q <= 1'b0;
         err_short_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dl_q <= cd_dat_download;
         len_q <= len_d;
         cnt_q <= cnt_d;
         wdata_q <= wdata_d;
         data_wr_q <= data_wr_d;
         aud_wr_q <= aud_wr_d;
         last_q <= last_d;
         last_aud_q <= last_aud_d;
         done_q <= last_q;
         is_aud_q <= is_aud_d;
         err_short_q <= err_short_d;
         err_ovf_q <= err_ovf_d;
      end
   cd_fifo_watermark #(.LEVEL_W(LEVEL_W), .DEPTH(DATA_DEPTH), .AF_MARGIN(AF_MARGIN)) u_data_wm (
      .clk_sys(clk_sys), .reset_n(reset_n), .level(data_level), .almost_full(CD_almost_full));
   cd_fifo_watermark #(.LEVEL_W(LEVEL_W), .DEPTH(AUD_DEPTH), .AF_MARGIN(AF_MARGIN)) u_aud_wm (
      .clk_sys(clk_sys), .reset_n(reset_n), .level(aud_level), .almost_full(AUDIO_almost_full));
   assign data_wr = data_wr_q;
   assign aud_wr = aud_wr_q;
   assign fifo_wdata = wdata_q;
   assign sector_done = done_q;
   assign sector_is_audio = is_aud_q;
   assign err_short = err_short_q;
   assign err_overflow = err_ovf_q;
endmodule

// File: tb/tb_cd_stream_router.sv
// tb_cd_stream_router: directed checks of sector routing, errors and watermarks.
module tb_cd_stream_router;
   localparam int LW = 12;
   localparam int DEPTH = 2048;
   logic clk_sys = 1'b0, reset_n = 1'b0, dl = 1'b0, wr = 1'b0, err_clr = 1'b0;
   logic [15:0] dout = '0;
   logic [LW-1:0] data_level = '0, aud_level = '0;
   logic data_wr, aud_wr, cd_af, aud_af, done, is_aud, e_short, e_ovf;
   logic [15:0] fifo_wdata;
   int vectors = 0, miscompares = 0;
   int n_dwr = 0, n_awr = 0, n_done = 0, bad_words = 0;
   int d0, a0, s0;
   logic [15:0] expq[$];

   cd_stream_router #(.LEVEL_W(LW), .DATA_DEPTH(DEPTH), .AUD_DEPTH(DEPTH), .AF_MARGIN(64)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .cd_dat_download(dl), .cdctl_wr(wr),
      .cd_data_out(dout), .data_level(data_level), .aud_level(aud_level),
      .data_wr(data_wr), .aud_wr(aud_wr), .fifo_wdata(fifo_wdata),
      .CD_almost_full(cd_af), .AUDIO_almost_full(aud_af), .sector_done(done),
      .sector_is_audio(is_aud), .err_short(e_short), .err_overflow(e_ovf), .err_clr(err_clr));

   always #5 clk_sys = ~clk_sys;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   always @(negedge clk_sys) if (reset_n) begin
      if (data_wr && aud_wr) bad_words++;
      if (data_wr) n_dwr++;
      if (aud_wr) n_awr++;
      if (data_wr || aud_wr) begin
         if (expq.size() == 0) bad_words++;
         else if (expq.pop_front() !== fifo_wdata) bad_words++;
      end
      if (done) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input logic [15:0] w, input bit keep);
      dout = w;
      wr = 1'b1;
      if (keep) expq.push_back(w);
      tick();
      wr = 1'b0;
   endtask

   task automatic start();
      dl = 1'b1;
      tick();
   endtask

   task automatic stop();
      dl = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic snap();
      d0 = n_dwr;
      a0 = n_awr;
      s0 = n_done;
   endtask

   initial begin
      tick();
      tick();
      check("reset_outs", {data_wr, aud_wr, fifo_wdata, cd_af, aud_af, done, is_aud, e_short, e_ovf}, 0);
      reset_n = 1'b1;
      tick();
      // Strobes with the download low are ignored.
      snap();
      send(16'h0001, 0);
      send(16'h1234, 0);
      tick();
      check("idle_ignore", n_dwr + n_awr - d0 - a0, 0);
      // One 1024-word data sector.
      snap();
      start();
      send(16'h0400, 0);
      for (int i = 0; i < 1024; i++) send(16'(i), 1);
      stop();
      check("data_dwr", n_dwr - d0, 1024);
      check("data_awr", n_awr - a0, 0);
      check("data_done", n_done - s0, 1);
      check("data_isaud", is_aud, 0);
      // Two 1176-word CDDA sectors back to back in one download.
      snap();
      start();
      for (int s = 0; s < 2; s++) begin
         send(16'h8498, 0);
         for (int i = 0; i < 1176; i++) send(16'h4000 + 16'(s * 2048 + i), 1);
      end
      stop();
      check("cdda_awr", n_awr - a0, 2352);
      check("cdda_dwr", n_dwr - d0, 0);
      check("cdda_done", n_done - s0, 2);
      check("cdda_isaud", is_aud, 1);
      // Short sector then a normal download.
      snap();
      start();
      send(16'h0010, 0);
      for (int i = 0; i < 5; i++) send(16'hA000 + 16'(i), 1);
      stop();
      check("short_dwr", n_dwr - d0, 5);
      check("short_done", n_done - s0, 0);
      check("short_err", e_short, 1);
      check("short_ovf", e_ovf, 0);
      snap();
      start();
      send(16'h0002, 0);
      send(16'hB001, 1);
      send(16'hB002, 1);
      stop();
      check("next_dwr", n_dwr - d0, 2);
      check("next_done", n_done - s0, 1);
      check("next_isaud", is_aud, 0);
      check("short_sticky", e_short, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("short_clr", e_short, 0);
      // Zero-length header: everything dropped until the download ends.
      snap();
      start();
      send(16'h0000, 0);
      for (int i = 0; i < 8; i++) send(16'h0001, 0);
      stop();
      check("zero_writes", n_dwr + n_awr - d0 - a0, 0);
      check("zero_done", n_done - s0, 0);
      check("zero_short", e_short, 0);
      // Full data FIFO on the third of eight words.
      snap();
      start();
      send(16'h0008, 0);
      for (int i = 0; i < 8; i++) begin
         data_level = i == 2 ? LW'(DEPTH) : '0;
         send(16'hC000 + 16'(i), i != 2);
      end
      data_level = '0;
      stop();
      check("ovf_dwr", n_dwr - d0, 7);
      check("ovf_err", e_ovf, 1);
      check("ovf_done", n_done - s0, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovf_clr", e_ovf, 0);
      // A clear coinciding with a new overflow loses.
      snap();
      start();
      send(16'h0001, 0);
      data_level = LW'(DEPTH);
      err_clr = 1'b1;
      send(16'hD000, 0);
      err_clr = 1'b0;
      data_level = '0;
      stop();
      check("clr_vs_err", e_ovf, 1);
      check("clr_done", n_done - s0, 1);
      check("clr_dwr", n_dwr - d0, 0);
      // Watermark sweeps.
      aud_level = LW'(DEPTH - 65);
      tick();
      check("aud_af_65", aud_af, 0);
      aud_level = LW'(DEPTH - 64);
      tick();
      check("aud_af_64", aud_af, 0);
      aud_level = LW'(DEPTH - 63);
      tick();
      check("aud_af_63", aud_af, 1);
      aud_level = '0;
      tick();
      check("aud_af_0", aud_af, 0);
      data_level = LW'(2000);
      tick();
      check("cd_af_48", cd_af, 1);
      data_level = '0;
      tick();
      check("cd_af_0", cd_af, 0);
      check("wdata_seq", bad_words, 0);
      check("queue_empty", expq.size(), 0);
      // Asynchronous reset in the middle of a sector.
      aud_level = LW'(DEPTH - 1);
      start();
      send(16'h0400, 0);
      for (int i = 0; i < 3; i++) send(16'hE000 + 16'(i), 1);
      check("pre_rst_wr", data_wr, 1);
      check("pre_rst_af", aud_af, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst", {data_wr, aud_wr, fifo_wdata, cd_af, aud_af, done, is_aud, e_short, e_ovf}, 0);
      expq.delete();
      dl = 1'b0;
      aud_level = '0;
      tick();
      reset_n = 1'b1;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
